// File: rtl/opti_divider.sv
// Signed Q(FW) restoring divider q = a / b, one quotient bit per cycle, fixed latency of ITERS+2 edges to out_valid.
// Accepts only when idle; the result is held in DONE until out_ready, so backpressure stalls the whole unit.
module opti_divider #(
    parameter int DW = 24,
    parameter int FW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] q,
    output logic          div_zero,
    output logic          sat,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int ITERS = FW + 1;
    localparam int CW    = $clog2(ITERS);
    localparam logic [DW-1:0]    Q_MAX   = (DW'(1) << FW) - DW'(1);
    localparam logic [DW-1:0]    Q_MIN   = ~Q_MAX;
    localparam logic [ITERS-1:0] MAG_ONE = ITERS'(1) << FW;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIN, S_DONE} state_t;

    state_t           r_state;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [DW-1:0]    r_rem;
    logic [ITERS-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_ovf;
    logic             r_zero;
    logic             r_azero;
    logic [DW-1:0]    r_q;
    logic             r_div_zero;
    logic             r_sat;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [DW-1:0]    w_abs_a;
    logic [DW-1:0]    w_abs_b;
    logic [DW:0]      w_rem2;
    logic             w_ge;
    logic [DW-1:0]    w_diff;
    logic [ITERS-1:0] w_mag;

    // |-2^(DW-1)| wraps to 2^(DW-1), which is the correct unsigned magnitude.
    assign w_abs_a = r_a[DW-1] ? (~r_a + DW'(1)) : r_a;
    assign w_abs_b = r_b[DW-1] ? (~r_b + DW'(1)) : r_b;

    // Remainder stays below |b| whenever the result is used, so the DW-bit difference is exact there.
    assign w_rem2 = {r_rem, 1'b0};
    assign w_ge   = (w_rem2 >= {1'b0, w_abs_b});
    assign w_diff = w_rem2[DW-1:0] - w_abs_b;

    // (Q + 1) >> 1 without the extra carry bit: round half away from zero on the magnitude.
    assign w_mag = {1'b0, r_quo[ITERS-1:1]} + ITERS'(r_quo[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_azero     <= 1'b0;
            r_q         <= '0;
            r_div_zero  <= 1'b0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_in_ready <= 1'b0;
                        r_state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_rem   <= w_abs_a;
                    r_quo   <= '0;
                    r_cnt   <= '0;
                    r_neg   <= r_a[DW-1] ^ r_b[DW-1];
                    r_ovf   <= (w_abs_a > w_abs_b) ||
                               ((w_abs_a == w_abs_b) && !(r_a[DW-1] ^ r_b[DW-1]));
                    r_zero  <= (r_b == '0);
                    r_azero <= (r_a == '0);
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_rem <= w_ge ? w_diff : w_rem2[DW-1:0];
                    r_quo <= {r_quo[ITERS-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(ITERS - 1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_div_zero <= r_zero;
                    if (r_zero && r_azero) begin
                        r_q   <= '0;
                        r_sat <= 1'b0;
                    end else if (r_zero) begin
                        r_q   <= r_a[DW-1] ? Q_MIN : Q_MAX;
                        r_sat <= 1'b1;
                    end else if (r_azero) begin
                        r_q   <= '0;
                        r_sat <= 1'b0;
                    end else if (r_ovf) begin
                        r_q   <= r_neg ? Q_MIN : Q_MAX;
                        r_sat <= 1'b1;
                    end else if (w_mag == MAG_ONE) begin
                        // -1.0 is representable, +1.0 is not.
                        r_q   <= r_neg ? Q_MIN : Q_MAX;
                        r_sat <= !r_neg;
                    end else begin
                        r_q   <= r_neg ? (~DW'(w_mag) + DW'(1)) : DW'(w_mag);
                        r_sat <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign q         = r_q;
    assign div_zero  = r_div_zero;
    assign sat       = r_sat;
    assign out_valid = r_out_valid;

endmodule
